// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
// Issue port (RS -> ALU) and common data bus (ALU -> RS/LSB/ROB) bundle.
//   issue : alu_enable, in_op, in_rs1, in_rs2, in_imm, in_pc, in_rd_rename,
//           alu_stall (back-pressure to the RS)
//   cdb   : cdb_valid, cdb_grant, cdb_value, cdb_rename, cdb_is_jump,
//           cdb_taken, cdb_target
// modport slave  : the execution unit's view
// modport master : the RS / CDB arbiter side
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 5,
  parameter int OP_W   = 6
) ();
  logic              alu_enable;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_pc;
  logic [ROB_W-1:0]  in_rd_rename;
  logic              alu_stall;
  logic              cdb_valid;
  logic              cdb_grant;
  logic [DATA_W-1:0] cdb_value;
  logic [ROB_W-1:0]  cdb_rename;
  logic              cdb_is_jump;
  logic              cdb_taken;
  logic [DATA_W-1:0] cdb_target;

  modport slave (
    input  alu_enable, in_op, in_rs1, in_rs2, in_imm, in_pc, in_rd_rename,
    input  cdb_grant,
    output alu_stall, cdb_valid, cdb_value, cdb_rename, cdb_is_jump,
    output cdb_taken, cdb_target
  );

  modport master (
    output alu_enable, in_op, in_rs1, in_rs2, in_imm, in_pc, in_rd_rename,
    output cdb_grant,
    input  alu_stall, cdb_valid, cdb_value, cdb_rename, cdb_is_jump,
    input  cdb_taken, cdb_target
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Integer execution unit: computes the result of an issued instruction in the
// issue cycle, stores it in a small result queue and broadcasts the queue head
// on the CDB under a valid/grant handshake.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   rdy           global enable; when low every register holds
//   jump_wrong    misprediction flush (drops queue and the current issue)
//   bus           issue + CDB bundle (alu_exec_unit_if.slave)
//   overflow_err  sticky: an issue arrived while the queue was full
// Opcodes (OPLEN set): LUI=1 AUIPC=2 JAL=3 JALR=4 BEQ..BGEU=5..10,
//   loads/stores 11..18 (not handled here, treated as undefined),
//   ADDI=19 SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI=27,
//   ADD=28 SUB SLL SLT SLTU XOR SRL SRA OR AND=37.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 5,
  parameter int OP_W   = 6,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  alu_exec_unit_if.slave    bus,
  output logic              overflow_err
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  localparam logic [OP_W-1:0] OP_LUI = 1,  OP_AUIPC = 2,  OP_JAL  = 3,  OP_JALR  = 4;
  localparam logic [OP_W-1:0] OP_BEQ = 5,  OP_BNE   = 6,  OP_BLT  = 7,  OP_BGE   = 8;
  localparam logic [OP_W-1:0] OP_BLTU = 9, OP_BGEU  = 10;
  localparam logic [OP_W-1:0] OP_ADDI = 19, OP_SLTI = 20, OP_SLTIU = 21, OP_XORI = 22;
  localparam logic [OP_W-1:0] OP_ORI  = 23, OP_ANDI = 24, OP_SLLI  = 25, OP_SRLI = 26;
  localparam logic [OP_W-1:0] OP_SRAI = 27;
  localparam logic [OP_W-1:0] OP_ADD = 28, OP_SUB = 29, OP_SLL = 30, OP_SLT = 31;
  localparam logic [OP_W-1:0] OP_SLTU = 32, OP_XOR = 33, OP_SRL = 34, OP_SRA = 35;
  localparam logic [OP_W-1:0] OP_OR  = 36, OP_AND = 37;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              is_jump;
    logic              taken;
    logic [DATA_W-1:0] target;
  } res_t;

  function automatic logic [DATA_W-1:0] flag(input logic c);
    return {{(DATA_W-1){1'b0}}, c};
  endfunction

  // R-type ops take rs2 as second operand, I-type ops take imm; branches
  // always compare rs1 against rs2.
  function automatic res_t alu_compute(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] rs1,
    input logic [DATA_W-1:0] rs2,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] pc
  );
    res_t                     r;
    logic [DATA_W-1:0]        b;
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [DATA_W-1:0] r2_s;
    logic [4:0]               sh;
    logic                     cond;
    r    = '0;
    b    = (op >= OP_ADD) ? rs2 : imm;
    a_s  = $signed(rs1);
    b_s  = $signed(b);
    r2_s = $signed(rs2);
    sh   = b[4:0];
    cond = 1'b0;
    case (op)
      OP_BEQ:  cond = (rs1 == rs2);
      OP_BNE:  cond = (rs1 != rs2);
      OP_BLT:  cond = (a_s < r2_s);
      OP_BGE:  cond = (a_s >= r2_s);
      OP_BLTU: cond = (rs1 < rs2);
      OP_BGEU: cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
    case (op)
      OP_LUI:   r.value = imm;
      OP_AUIPC: r.value = pc + imm;
      OP_JAL: begin
        r.value = pc + 4; r.target = pc + imm; r.is_jump = 1'b1; r.taken = 1'b1;
      end
      OP_JALR: begin
        r.value  = pc + 4;
        r.target = (rs1 + imm) & ~{{(DATA_W-1){1'b0}}, 1'b1};
        r.is_jump = 1'b1; r.taken = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        r.is_jump = 1'b1;
        r.taken   = cond;
        r.target  = cond ? (pc + imm) : (pc + 4);
      end
      OP_ADDI, OP_ADD:   r.value = rs1 + b;
      OP_SUB:            r.value = rs1 - rs2;
      OP_SLTI, OP_SLT:   r.value = flag(a_s < b_s);
      OP_SLTIU, OP_SLTU: r.value = flag(rs1 < b);
      OP_XORI, OP_XOR:   r.value = rs1 ^ b;
      OP_ORI, OP_OR:     r.value = rs1 | b;
      OP_ANDI, OP_AND:   r.value = rs1 & b;
      OP_SLLI, OP_SLL:   r.value = rs1 << sh;
      OP_SRLI, OP_SRL:   r.value = rs1 >> sh;
      OP_SRAI, OP_SRA:   r.value = $unsigned(a_s >>> sh);
      default:           r = '0;
    endcase
    return r;
  endfunction

  // ---- stage p0: combinational result of the current issue ----
  res_t res_p0;
  assign res_p0 = alu_compute(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_pc);

  // ---- stage p1: result queue (registered storage, head drives the CDB) ----
  res_t             q_res_p1 [QDEPTH];
  logic [ROB_W-1:0] q_tag_p1 [QDEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             vld_p1;
  logic             pop, push, drop;

  assign vld_p1 = (count != '0);
  assign pop    = vld_p1 && bus.cdb_grant && rdy && !jump_wrong;
  // A pop on the same edge frees the slot, so a full queue can still accept.
  assign push   = rdy && !jump_wrong && bus.alu_enable && ((count < FULL) || pop);
  assign drop   = rdy && !jump_wrong && bus.alu_enable && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_res_p1[i] <= '0;
        q_tag_p1[i] <= '0;
      end
    end else if (rdy) begin
      if (jump_wrong) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop) head <= head + 1'b1;
        if (push) begin
          q_res_p1[tail] <= res_p0;
          q_tag_p1[tail] <= bus.in_rd_rename;
          tail           <= tail + 1'b1;
        end
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (drop) overflow_err <= 1'b1;
      end
    end
  end

  assign bus.cdb_valid   = vld_p1;
  assign bus.alu_stall   = (count == FULL);
  assign bus.cdb_value   = q_res_p1[head].value;
  assign bus.cdb_is_jump = q_res_p1[head].is_jump;
  assign bus.cdb_taken   = q_res_p1[head].taken;
  assign bus.cdb_target  = q_res_p1[head].target;
  assign bus.cdb_rename  = q_tag_p1[head];
endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed scenarios plus randomized traffic against a queue-based reference
// model of the execution unit.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
  localparam bit [5:0] LUI = 1, AUIPC = 2, JAL = 3, JALR = 4;
  localparam bit [5:0] BEQ = 5, BNE = 6, BLT = 7, BGE = 8, BLTU = 9, BGEU = 10;
  localparam bit [5:0] ADDI = 19, SLTI = 20, SLTIU = 21, XORI = 22, ORI = 23;
  localparam bit [5:0] ANDI = 24, SLLI = 25, SRLI = 26, SRAI = 27;
  localparam bit [5:0] ADD = 28, SUB = 29, SLL = 30, SLT = 31, SLTU = 32;
  localparam bit [5:0] XOR = 33, SRL = 34, SRA = 35, OR = 36, AND = 37;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic jump_wrong = 1'b0;
  logic overflow_err;

  alu_exec_unit_if #(.DATA_W(32), .ROB_W(5), .OP_W(6)) bus ();

  alu_exec_unit #(.DATA_W(32), .ROB_W(5), .OP_W(6), .QDEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .jump_wrong   (jump_wrong),
    .bus          (bus),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] value;
    bit [4:0]  tag;
    bit        is_jump;
    bit        taken;
    bit [31:0] target;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural result of one instruction, straight from the ISA rules.
  function automatic ent_t model_op(input bit [5:0] op, input bit [31:0] a,
                                    input bit [31:0] b, input bit [31:0] imm,
                                    input bit [31:0] pc);
    ent_t e;
    int   sa, sb, si;
    bit   t;
    e = '{default: 0};
    sa = a; sb = b; si = imm;
    t = 0;
    case (op)
      LUI:   e.value = imm;
      AUIPC: e.value = pc + imm;
      JAL:   begin e.value = pc + 4; e.target = pc + imm; e.is_jump = 1; e.taken = 1; end
      JALR:  begin e.value = pc + 4; e.target = (a + imm) & 32'hFFFF_FFFE; e.is_jump = 1; e.taken = 1; end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        if (op == BEQ)  t = (a == b);
        if (op == BNE)  t = (a != b);
        if (op == BLT)  t = (sa < sb);
        if (op == BGE)  t = (sa >= sb);
        if (op == BLTU) t = (a < b);
        if (op == BGEU) t = (a >= b);
        e.is_jump = 1; e.taken = t;
        e.target = t ? pc + imm : pc + 4;
      end
      ADDI:  e.value = a + imm;
      SLTI:  e.value = (sa < si) ? 1 : 0;
      SLTIU: e.value = (a < imm) ? 1 : 0;
      XORI:  e.value = a ^ imm;
      ORI:   e.value = a | imm;
      ANDI:  e.value = a & imm;
      SLLI:  e.value = a << imm[4:0];
      SRLI:  e.value = a >> imm[4:0];
      SRAI:  e.value = sa >>> imm[4:0];
      ADD:   e.value = a + b;
      SUB:   e.value = a - b;
      SLL:   e.value = a << b[4:0];
      SLT:   e.value = (sa < sb) ? 1 : 0;
      SLTU:  e.value = (a < b) ? 1 : 0;
      XOR:   e.value = a ^ b;
      SRL:   e.value = a >> b[4:0];
      SRA:   e.value = sa >>> b[4:0];
      OR:    e.value = a | b;
      AND:   e.value = a & b;
      default: e.value = 0;
    endcase
    return e;
  endfunction

  task automatic compare_all();
    chk("cdb_valid", bus.cdb_valid, mq.size() != 0);
    chk("alu_stall", bus.alu_stall, mq.size() == 2);
    chk("overflow_err", overflow_err, m_ovf);
    if (mq.size() != 0) begin
      chk("cdb_value", bus.cdb_value, mq[0].value);
      chk("cdb_rename", bus.cdb_rename, mq[0].tag);
      chk("cdb_is_jump", bus.cdb_is_jump, mq[0].is_jump);
      chk("cdb_taken", bus.cdb_taken, mq[0].taken);
      chk("cdb_target", bus.cdb_target, mq[0].target);
    end
  endtask

  // Update the model from the inputs present before the edge, clock once, check.
  task automatic cycle();
    ent_t e;
    bit   pop, push;
    e = model_op(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_pc);
    e.tag = bus.in_rd_rename;
    if (rdy) begin
      if (jump_wrong) mq.delete();
      else begin
        pop  = (mq.size() > 0) && bus.cdb_grant;
        push = bus.alu_enable && (mq.size() < 2 || pop);
        if (bus.alu_enable && !push) m_ovf = 1;
        if (pop) mq.delete(0);
        if (push) mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit en, input bit [5:0] op, input bit [31:0] a,
                       input bit [31:0] b, input bit [31:0] imm,
                       input bit [31:0] pc, input bit [4:0] tag, input bit grant);
    bus.alu_enable   = en;
    bus.in_op        = op;
    bus.in_rs1       = a;
    bus.in_rs2       = b;
    bus.in_imm       = imm;
    bus.in_pc        = pc;
    bus.in_rd_rename = tag;
    bus.cdb_grant    = grant;
  endtask

  task automatic idle(input bit grant);
    drive(0, 0, 0, 0, 0, 0, 0, grant);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", bus.cdb_valid, 1'b0);
    chk("rst_stall", bus.alu_stall, 1'b0);
    chk("rst_ovf", overflow_err, 1'b0);
    chk("rst_value", bus.cdb_value, 32'h0);
    chk("rst_rename", bus.cdb_rename, 5'h0);
    chk("rst_target", bus.cdb_target, 32'h0);
    rst = 1'b0;
    mq.delete();
    m_ovf = 0;
  endtask

  bit [5:0] ops [33] = '{LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
                         ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
                         ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
                         6'd0, 6'd12, 6'd40, 6'd63};

  function automatic bit [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle(0);
    m_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("init_value", bus.cdb_value, 32'h0);
    rst = 1'b0;

    // ADD wrap-around, broadcast one cycle after issue, then empty.
    drive(1, ADD, 32'hFFFF_FFFF, 2, 0, 0, 3, 1); cycle();
    chk("add_valid", bus.cdb_valid, 1'b1);
    chk("add_value", bus.cdb_value, 32'h1);
    chk("add_rename", bus.cdb_rename, 5'd3);
    chk("add_is_jump", bus.cdb_is_jump, 1'b0);
    idle(1); cycle();
    chk("add_empty", bus.cdb_valid, 1'b0);

    // Back-pressure and overflow.
    drive(1, SUB, 5, 7, 0, 0, 1, 0); cycle();
    drive(1, SRA, 32'h8000_0000, 4, 0, 0, 2, 0); cycle();
    chk("bp_stall", bus.alu_stall, 1'b1);
    drive(1, ADD, 1, 1, 0, 0, 7, 0); cycle();
    chk("bp_ovf", overflow_err, 1'b1);
    chk("bp_head1", bus.cdb_value, 32'hFFFF_FFFE);
    chk("bp_tag1", bus.cdb_rename, 5'd1);
    idle(1); cycle();
    chk("bp_head2", bus.cdb_value, 32'hF800_0000);
    chk("bp_tag2", bus.cdb_rename, 5'd2);
    idle(1); cycle();
    chk("bp_empty", bus.cdb_valid, 1'b0);

    // Full queue with simultaneous pop and push.
    do_reset();
    drive(1, ADDI, 10, 0, 1, 0, 5, 0); cycle();
    drive(1, ADDI, 20, 0, 2, 0, 6, 0); cycle();
    drive(1, XORI, 32'hF0, 0, 32'hFF, 0, 4, 1); cycle();
    chk("pp_stall", bus.alu_stall, 1'b1);
    chk("pp_ovf", overflow_err, 1'b0);
    chk("pp_head", bus.cdb_rename, 5'd6);
    idle(1); cycle();
    chk("pp_tag4", bus.cdb_rename, 5'd4);
    chk("pp_val4", bus.cdb_value, 32'h0F);
    idle(1); cycle();

    // Branches and JALR.
    drive(1, BLT, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 8, 1); cycle();
    chk("blt_taken", bus.cdb_taken, 1'b1);
    chk("blt_target", bus.cdb_target, 32'h120);
    chk("blt_jump", bus.cdb_is_jump, 1'b1);
    drive(1, BLTU, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 9, 1); cycle();
    chk("bltu_taken", bus.cdb_taken, 1'b0);
    chk("bltu_target", bus.cdb_target, 32'h104);
    drive(1, JALR, 32'h203, 0, 0, 32'h40, 10, 1); cycle();
    chk("jalr_value", bus.cdb_value, 32'h44);
    chk("jalr_target", bus.cdb_target, 32'h202);
    idle(1); cycle();

    // Flush with a pending issue, then rdy low holds the head.
    drive(1, ADD, 1, 2, 0, 0, 11, 0); cycle();
    drive(1, ADD, 3, 4, 0, 0, 12, 0); cycle();
    jump_wrong = 1'b1;
    drive(1, ADD, 5, 6, 0, 0, 13, 1); cycle();
    jump_wrong = 1'b0;
    chk("fl_valid", bus.cdb_valid, 1'b0);
    chk("fl_stall", bus.alu_stall, 1'b0);
    drive(1, LUI, 0, 0, 32'h1234_5000, 0, 14, 0); cycle();
    rdy = 1'b0;
    drive(1, ADD, 1, 1, 0, 0, 15, 1);
    repeat (3) cycle();
    chk("hold_tag", bus.cdb_rename, 5'd14);
    chk("hold_value", bus.cdb_value, 32'h1234_5000);
    rdy = 1'b1;
    idle(1); cycle();

    // Reset mid-operation with a full queue and overflow set.
    drive(1, ADD, 1, 1, 0, 0, 16, 0); cycle();
    drive(1, ADD, 2, 2, 0, 0, 17, 0); cycle();
    drive(1, ADD, 3, 3, 0, 0, 18, 0); cycle();
    chk("pre_rst_ovf", overflow_err, 1'b1);
    do_reset();
    drive(1, OR, 32'hA0, 32'h0B, 0, 0, 19, 1); cycle();
    chk("post_rst_value", bus.cdb_value, 32'hAB);
    chk("post_rst_tag", bus.cdb_rename, 5'd19);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rdy        = ($urandom_range(0, 9) != 0);
      jump_wrong = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 9) < 7, ops[$urandom_range(0, 32)], rnd_val(), rnd_val(),
            rnd_val(), $urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 30)),
            $urandom_range(0, 9) < 6);
      cycle();
      if (i % 1000 == 999) do_reset();
    end
    rdy = 1'b1;
    jump_wrong = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
